// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundle between the fetch pipeline and the PC controller.
//   master  : pipeline side; drives pc, stall and the redirect requests
//             and receives npc/pc_wr/srr0_wr/srr0_val/state.
//   slave   : pc_ctrl side (mirror image of master).
// Parameter PC_WIDTH sets the width of every address signal.
interface pc_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc;
  logic                stall;
  logic                br_req;
  logic [PC_WIDTH-1:0] br_target;
  logic                exc_req;
  logic [PC_WIDTH-1:0] exc_vec;
  logic                irq;
  logic                msr_ee;
  logic                rfi_req;
  logic [PC_WIDTH-1:0] srr0;
  logic [PC_WIDTH-1:0] npc;
  logic                pc_wr;
  logic                srr0_wr;
  logic [PC_WIDTH-1:0] srr0_val;
  logic [1:0]          state;

  modport master (
    output pc, stall, br_req, br_target, exc_req, exc_vec,
           irq, msr_ee, rfi_req, srr0,
    input  npc, pc_wr, srr0_wr, srr0_val, state
  );

  modport slave (
    input  pc, stall, br_req, br_target, exc_req, exc_vec,
           irq, msr_ee, rfi_req, srr0,
    output npc, pc_wr, srr0_wr, srr0_val, state
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC selection and redirect sequencing for the fetch stage.
//   Picks the next PC from exception, external interrupt, return from
//   interrupt, taken branch or sequential (pc+4), writes it the same cycle,
//   inserts one bubble cycle after any redirect and holds a one-entry
//   pending redirect while the pipeline is stalled.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - pc_ctrl_if.slave (pc/stall/requests in, npc/pc_wr/srr0_* out,
//          state out: INIT=0, RUN=1, HOLD=2, REDIR=3)
// Build option:
//   PC_CTRL_IRQ_EN - when defined, irq/msr_ee form an external-interrupt
//   source vectoring to EXT_VEC; when undefined those inputs are ignored.
module pc_ctrl #(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] EXT_VEC   = 32'h0000_0500
) (
  input  logic       clk,
  input  logic       rst,
  pc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  // Numeric order doubles as priority order (larger wins).
  typedef enum logic [2:0] {
    RQ_NONE = 3'd0,
    RQ_BR   = 3'd1,
    RQ_RFI  = 3'd2,
    RQ_IRQ  = 3'd3,
    RQ_EXC  = 3'd4
  } req_t;

  state_t              state_q, state_d;
  req_t                pend_type_q, pend_type_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic [PC_WIDTH-1:0] pc_seq;
  logic                irq_take;
  req_t                live_type, sel_type;
  logic [PC_WIDTH-1:0] live_tgt, sel_tgt;

  logic [PC_WIDTH-1:0] npc;
  logic                pc_wr;
  logic                srr0_wr;
  logic [PC_WIDTH-1:0] srr0_val;

  assign pc_seq = bus.pc + PC_WIDTH'(4);

`ifdef PC_CTRL_IRQ_EN
  // An rfi in flight (live or pending) masks the interrupt so the return
  // completes first; the bubble after it ignores all requests anyway.
  assign irq_take = bus.irq & bus.msr_ee & ~bus.rfi_req &
                    (pend_type_q != RQ_RFI);
`else
  logic unused_irq;
  assign unused_irq = bus.irq ^ bus.msr_ee;
  assign irq_take   = 1'b0;
`endif

  // Live request by priority, then merged with the pending entry. On a tie
  // the older pending entry is kept.
  always_comb begin
    live_type = RQ_NONE;
    live_tgt  = pc_seq;
    if (bus.exc_req) begin
      live_type = RQ_EXC;
      live_tgt  = bus.exc_vec;
    end else if (irq_take) begin
      live_type = RQ_IRQ;
      live_tgt  = EXT_VEC;
    end else if (bus.rfi_req) begin
      live_type = RQ_RFI;
      live_tgt  = bus.srr0;
    end else if (bus.br_req) begin
      live_type = RQ_BR;
      live_tgt  = bus.br_target;
    end

    sel_type = live_type;
    sel_tgt  = live_tgt;
    if ((pend_type_q != RQ_NONE) && (pend_type_q >= live_type)) begin
      sel_type = pend_type_q;
      sel_tgt  = pend_tgt_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_type_d = pend_type_q;
    pend_tgt_d  = pend_tgt_q;
    npc         = pc_seq;
    pc_wr       = 1'b0;
    srr0_wr     = 1'b0;
    srr0_val    = '0;
    case (state_q)
      ST_INIT: begin
        npc         = RESET_VEC;
        pc_wr       = 1'b1;
        pend_type_d = RQ_NONE;
        state_d     = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (bus.stall) begin
          // sel_* already keeps the pending entry unless the live one outranks it.
          state_d     = ST_HOLD;
          pend_type_d = sel_type;
          pend_tgt_d  = sel_tgt;
        end else begin
          pc_wr       = 1'b1;
          npc         = sel_tgt;
          pend_type_d = RQ_NONE;
          state_d     = (sel_type == RQ_NONE) ? ST_RUN : ST_REDIR;
          if (sel_type == RQ_EXC) begin
            srr0_wr  = 1'b1;
            srr0_val = bus.pc;
          end else if (sel_type == RQ_IRQ) begin
            srr0_wr  = 1'b1;
            srr0_val = pc_seq;
          end
        end
      end
      default: begin
        // Bubble after a redirect: requests are not looked at here.
        state_d = bus.stall ? ST_HOLD : ST_RUN;
      end
    endcase
    if (rst) begin
      npc      = RESET_VEC;
      pc_wr    = 1'b0;
      srr0_wr  = 1'b0;
      srr0_val = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      pend_type_q <= RQ_NONE;
    end else begin
      state_q     <= state_d;
      pend_type_q <= pend_type_d;
    end
  end

  // Target is only meaningful while pend_type_q is not RQ_NONE.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign bus.npc      = npc;
  assign bus.pc_wr    = pc_wr;
  assign bus.srr0_wr  = srr0_wr;
  assign bus.srr0_val = srr0_val;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: scenario tasks drive a table of per-cycle stimulus,
// push the expected outputs into a scoreboard queue and pop/compare them at
// the following falling edge. The PC register is modelled by the bench from
// its own expected npc values.
module tb_pc_ctrl;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_REDIR = 2'd3;

  typedef struct packed {
    logic [1:0]  st;
    logic        wr;
    logic [31:0] npc;
    logic        swr;
    logic [31:0] sval;
  } out_t;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] ev;
    logic        rfi;
    logic [31:0] s0;
    logic        irq;
    logic        ee;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_m = '0;
  out_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  pc_ctrl_if #(.PC_WIDTH(32)) bus ();

  pc_ctrl #(
    .PC_WIDTH (32),
    .RESET_VEC(32'h0000_0000),
    .EXT_VEC  (32'h0000_0500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(bit stall, bit br, logic [31:0] bt, bit exc,
                               logic [31:0] ev, bit rfi, logic [31:0] s0,
                               bit irq, bit ee);
    stim_t s;
    s.stall = stall; s.br = br; s.bt = bt; s.exc = exc; s.ev = ev;
    s.rfi = rfi; s.s0 = s0; s.irq = irq; s.ee = ee;
    return s;
  endfunction

  // npc / srr0_val are don't-care when their strobes are low.
  function automatic out_t E(logic [1:0] st, bit wr, logic [31:0] npc,
                             bit swr, logic [31:0] sval);
    out_t o;
    o.st = st; o.wr = wr; o.npc = wr ? npc : 32'h0;
    o.swr = swr; o.sval = swr ? sval : 32'h0;
    return o;
  endfunction

  function automatic out_t obs();
    out_t o;
    o.st = bus.state; o.wr = bus.pc_wr; o.npc = bus.npc;
    o.swr = bus.srr0_wr; o.sval = bus.srr0_val;
    return o;
  endfunction

  function automatic out_t obs_m();
    out_t o;
    o = obs();
    if (!o.wr)  o.npc  = '0;
    if (!o.swr) o.sval = '0;
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("st=%0d wr=%0b npc=%h swr=%0b sval=%h",
                     o.st, o.wr, o.npc, o.swr, o.sval);
  endfunction

  task automatic drive(input stim_t s);
    bus.pc = pc_m; bus.stall = s.stall;
    bus.br_req = s.br; bus.br_target = s.bt;
    bus.exc_req = s.exc; bus.exc_vec = s.ev;
    bus.rfi_req = s.rfi; bus.srr0 = s.s0;
    bus.irq = s.irq; bus.msr_ee = s.ee;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    pc_m = '0;
  endtask

  task automatic test_reset();
    stim_t s[4]; out_t x[4]; bit r[4]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);          r[0] = 1; x[0] = E(S_INIT, 0, 0, 0, 0);
    s[1] = mk(0, 1, 32'h80, 1, 32'h700, 0, 0, 0, 0); r[1] = 1; x[1] = E(S_INIT, 0, 0, 0, 0);
    s[2] = mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);     r[2] = 0; x[2] = E(S_INIT, 1, 32'h0, 0, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);          r[3] = 0; x[3] = E(S_RUN, 1, 32'h4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rst = r[i];
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = r[i] ? obs() : obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_seq();
    out_t x[4]; out_t e, o;
    x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    x[1] = E(S_RUN, 1, 32'h4, 0, 0);
    x[2] = E(S_RUN, 1, 32'h8, 0, 0);
    x[3] = E(S_RUN, 1, 32'hC, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL seq[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_branch();
    stim_t s[4]; out_t x[4]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(0, 1, 32'h200, 0, 0, 0, 0, 0, 0); x[1] = E(S_RUN, 1, 32'h200, 0, 0);
    s[2] = mk(0, 1, 32'h990, 0, 0, 0, 0, 0, 0); x[2] = E(S_REDIR, 0, 0, 0, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[3] = E(S_RUN, 1, 32'h204, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) pc_m = 32'h100;
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL branch[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_stall_exc();
    stim_t s[7]; out_t x[7]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(1, 1, 32'h300, 0, 0, 0, 0, 0, 0); x[1] = E(S_RUN, 0, 0, 0, 0);
    s[2] = mk(1, 0, 0, 1, 32'h700, 0, 0, 0, 0); x[2] = E(S_HOLD, 0, 0, 0, 0);
    s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);       x[3] = E(S_HOLD, 0, 0, 0, 0);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[4] = E(S_HOLD, 1, 32'h700, 1, 32'h600);
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[5] = E(S_REDIR, 0, 0, 0, 0);
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[6] = E(S_RUN, 1, 32'h704, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) pc_m = 32'h600;
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall_exc[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_pending_prio();
    stim_t s[8]; out_t x[8]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(1, 0, 0, 1, 32'h700, 0, 0, 0, 0);     x[1] = E(S_RUN, 0, 0, 0, 0);
    s[2] = mk(1, 1, 32'h300, 0, 0, 0, 0, 0, 0);     x[2] = E(S_HOLD, 0, 0, 0, 0);
    s[3] = mk(0, 1, 32'h380, 0, 0, 0, 0, 0, 0);     x[3] = E(S_HOLD, 1, 32'h700, 1, 32'h600);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[4] = E(S_REDIR, 0, 0, 0, 0);
    s[5] = mk(1, 1, 32'h300, 0, 0, 0, 0, 0, 0);     x[5] = E(S_RUN, 0, 0, 0, 0);
    s[6] = mk(0, 0, 0, 0, 0, 1, 32'h880, 0, 0);     x[6] = E(S_HOLD, 1, 32'h880, 0, 0);
    s[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[7] = E(S_REDIR, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) pc_m = 32'h600;
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL pend_prio[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_irq();
    stim_t s[8]; out_t x[8]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(0, 1, 32'h200, 0, 0, 0, 0, 1, 1);
`ifdef PC_CTRL_IRQ_EN
    x[1] = E(S_RUN, 1, 32'h500, 1, 32'h404);
`else
    x[1] = E(S_RUN, 1, 32'h200, 0, 0);
`endif
    s[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[2] = E(S_REDIR, 0, 0, 0, 0);
    s[3] = mk(0, 1, 32'h240, 0, 0, 0, 0, 1, 0);     x[3] = E(S_RUN, 1, 32'h240, 0, 0);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);           x[4] = E(S_REDIR, 0, 0, 0, 0);
    s[5] = mk(0, 0, 0, 0, 0, 1, 32'h120, 1, 1);     x[5] = E(S_RUN, 1, 32'h120, 0, 0);
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);           x[6] = E(S_REDIR, 0, 0, 0, 0);
    s[7] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef PC_CTRL_IRQ_EN
    x[7] = E(S_RUN, 1, 32'h500, 1, 32'h124);
`else
    x[7] = E(S_RUN, 1, 32'h124, 0, 0);
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 1 || i == 3) pc_m = 32'h400;
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL irq[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_rst_hold();
    stim_t s[6]; out_t x[6]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(1, 1, 32'h300, 0, 0, 0, 0, 0, 0); x[1] = E(S_RUN, 0, 0, 0, 0);
    s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);       x[2] = E(S_HOLD, 0, 0, 0, 0);
    s[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);       x[3] = E(S_INIT, 0, 0, 0, 0);
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[4] = E(S_INIT, 1, 32'h0, 0, 0);
    s[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[5] = E(S_RUN, 1, 32'h4, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 1) pc_m = 32'h100;
      rst = (i == 3);
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = rst ? obs() : obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rst_hold[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    out_t x[3]; out_t e, o;
    x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    x[1] = E(S_RUN, 1, 32'h0, 0, 0);
    x[2] = E(S_RUN, 1, 32'h4, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) pc_m = 32'hFFFF_FFFC;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wrap[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[7]; out_t x[7]; out_t e, o;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[0] = E(S_INIT, 1, 32'h0, 0, 0);
    s[1] = mk(0, 0, 0, 1, 32'h700, 0, 0, 0, 0); x[1] = E(S_RUN, 1, 32'h700, 1, 32'h40);
    s[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);       x[2] = E(S_REDIR, 0, 0, 0, 0);
    s[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[3] = E(S_HOLD, 1, 32'h704, 0, 0);
    s[4] = mk(0, 1, 32'h900, 0, 0, 0, 0, 0, 0); x[4] = E(S_RUN, 1, 32'h900, 0, 0);
    s[5] = mk(0, 1, 32'hA00, 0, 0, 0, 0, 0, 0); x[5] = E(S_REDIR, 0, 0, 0, 0);
    s[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);       x[6] = E(S_RUN, 1, 32'h904, 0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) pc_m = 32'h40;
      drive(s[i]); sb.push_back(x[i]);
      @(negedge clk); e = sb.pop_front(); o = obs_m();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL b2b[%0d] got %s want %s", i, fmt(o), fmt(e)); end
      @(posedge clk); #1; if (e.wr) pc_m = e.npc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_stall_exc();
    test_pending_prio();
    test_irq();
    test_rst_hold();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
